// File: rtl/target_burst_buf.sv
// Target-side burst buffer: select handshake, tagged writes into a circular store,
// fixed-length read bursts with sticky overflow/underflow flags. Optional checks: TARGET_BURST_BUF_SVA_EN.
module target_burst_buf #(
   parameter  int DATA_W    = 8,
   parameter  int DEPTH     = 64,
   parameter  int BURST_LEN = 8,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sel_bit,
   input  logic [DATA_W:0]   datain,
   input  logic              rd_req,
   input  logic              err_clr,
   output logic              trdy,
   output logic [DATA_W-1:0] dataout,
   output logic              dout_vld,
   output logic [AW-1:0]     ri,
   output logic [AW-1:0]     wi,
   output logic [AW:0]       count,
   output logic              full,
   output logic              empty,
   output logic              ovf_err,
   output logic              udf_err
);

   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, ARM, ACTIVE, READ} state_t;

   state_t            state, state_nx;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [CW-1:0]     bcnt;
   logic              tag;
   logic              act;
   logic              push_req;
   logic              push;
   logic              pop;
   logic              start_req;
   logic              start_ok;
   logic              start_bad;
   logic              burst_done;

   assign tag        = datain[DATA_W];
   assign act        = (state == ACTIVE) || (state == READ);
   // A deselect sampled in READ aborts before the next word leaves.
   assign pop        = (state == READ) && sel_bit;
   assign push_req   = act && tag;
   assign push       = push_req && (!full || pop);
   assign start_req  = (state == ACTIVE) && sel_bit && rd_req && !tag;
   assign start_ok   = start_req && (count >= CW'(BURST_LEN));
   assign start_bad  = start_req && !start_ok;
   assign burst_done = pop && (bcnt == CW'(BURST_LEN - 1));

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      trdy     = 1'b1;
      case (state)
         IDLE:   if (sel_bit) state_nx = ARM;
         ARM:    state_nx = sel_bit ? ACTIVE : IDLE;
         ACTIVE: begin
            trdy = 1'b0;
            if (!sel_bit)      state_nx = IDLE;
            else if (start_ok) state_nx = READ;
         end
         READ: begin
            trdy = 1'b0;
            if (!sel_bit)        state_nx = IDLE;
            else if (burst_done) state_nx = ACTIVE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push) mem[wi] <= datain[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wi <= '0;
         ri <= '0;
      end else begin
         if (push) wi <= wi + 1'b1;
         if (pop)  ri <= ri + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout_vld <= 1'b0;
         dataout  <= '0;
         bcnt     <= '0;
      end else begin
         dout_vld <= pop;
         dataout  <= pop ? mem[ri] : '0;
         if (start_ok) bcnt <= '0;
         else if (pop) bcnt <= bcnt + 1'b1;
      end
   end

   // New error in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_err <= 1'b0;
         udf_err <= 1'b0;
      end else begin
         ovf_err <= (ovf_err && !err_clr) || (push_req && !push);
         udf_err <= (udf_err && !err_clr) || start_bad;
      end
   end

`ifdef TARGET_BURST_BUF_SVA_EN
   a_sel_arm: assert property (@(posedge clk) disable iff (!reset)
      (state == IDLE && sel_bit) |=> trdy)
      else $error("select: trdy not high one cycle after select");
   a_sel_act: assert property (@(posedge clk) disable iff (!reset)
      (state == ARM && sel_bit) |=> !trdy)
      else $error("select: trdy not low two cycles after select");
   a_sel_fall: assert property (@(posedge clk) disable iff (!reset)
      (state != IDLE && !sel_bit) |=> trdy)
      else $error("deselect: trdy not high next cycle");
   a_wi_inc: assert property (@(posedge clk) disable iff (!reset)
      push |=> (wi == AW'($past(wi) + 1'b1)))
      else $error("write pointer did not advance");
   a_ri_inc: assert property (@(posedge clk) disable iff (!reset)
      pop |=> (ri == AW'($past(ri) + 1'b1)))
      else $error("read pointer did not advance");
   a_cnt_max: assert property (@(posedge clk) disable iff (!reset)
      count <= CW'(DEPTH))
      else $error("count exceeds DEPTH");
   a_din_x: assert property (@(posedge clk) disable iff (!reset)
      (act && tag) |-> !$isunknown(datain))
      else $error("X on datain during write");
`endif

endmodule

// File: tb/tb_target_burst_buf.sv
// Bench for target_burst_buf: table of per-cycle vectors plus hand sequences for
// overflow, push/pop while full, abort, pointer wrap and mid-burst reset; burst data via scoreboard.
module tb_target_burst_buf;

   localparam int DATA_W = 8;
   localparam int AW     = 6;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              sel_bit = 1'b0;
   logic [DATA_W:0]   datain = '0;
   logic              rd_req = 1'b0;
   logic              err_clr = 1'b0;
   logic              trdy, dout_vld, full, empty, ovf_err, udf_err;
   logic [DATA_W-1:0] dataout;
   logic [AW-1:0]     ri, wi;
   logic [AW:0]       count;

   int                n_chk = 0;
   int                n_fail = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] sb_e;

   typedef struct {
      logic       sel, tag;
      logic [7:0] pay;
      logic       rd, clr;
      logic       trdy;
      int         ri, wi, cnt;
      logic       vld, ovf, udf;
   } vec_t;
   vec_t tbl[$];

   target_burst_buf dut (
      .clk(clk), .reset(reset), .sel_bit(sel_bit), .datain(datain), .rd_req(rd_req),
      .err_clr(err_clr), .trdy(trdy), .dataout(dataout), .dout_vld(dout_vld),
      .ri(ri), .wi(wi), .count(count), .full(full), .empty(empty),
      .ovf_err(ovf_err), .udf_err(udf_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_st(input string nm, input logic t, input int r, input int w, input int c,
                         input logic v, input logic o, input logic u);
      chk({nm, ".trdy"},  32'(trdy), 32'(t));
      chk({nm, ".ri"},    32'(ri), r);
      chk({nm, ".wi"},    32'(wi), w);
      chk({nm, ".count"}, 32'(count), c);
      chk({nm, ".empty"}, 32'(empty), 32'(c == 0));
      chk({nm, ".full"},  32'(full), 32'(c == 64));
      chk({nm, ".vld"},   32'(dout_vld), 32'(v));
      chk({nm, ".ovf"},   32'(ovf_err), 32'(o));
      chk({nm, ".udf"},   32'(udf_err), 32'(u));
      if (!v) chk({nm, ".dout0"}, 32'(dataout), 0);
   endtask

   // Scoreboard: every burst beat must match the oldest expected word.
   always @(negedge clk) begin
      if (reset && dout_vld) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_extra: dataout=%0h with no expected word", dataout);
         end else begin
            sb_e = exp_q.pop_front();
            chk("sb_data", 32'(dataout), 32'(sb_e));
         end
      end
   end

   task automatic cyc(input logic s, input logic t, input logic [7:0] p, input logic r,
                      input logic c, input logic psh);
      sel_bit = s;
      datain  = {t, p};
      rd_req  = r;
      err_clr = c;
      if (psh) exp_q.push_back(p);
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic s, t, input logic [7:0] p, input logic r, c,
                               input logic et, input int er, ew, ec, input logic ev, eo, eu);
      vec_t x;
      x.sel = s; x.tag = t; x.pay = p; x.rd = r; x.clr = c;
      x.trdy = et; x.ri = er; x.wi = ew; x.cnt = ec; x.vld = ev; x.ovf = eo; x.udf = eu;
      return x;
   endfunction

   initial begin
      // select handshake, 8 writes, one burst, repeated data, underflow, error clear
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(1, 1, 8'(8'h11 + i), 0, 0, 0, 0, i + 1, i + 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 8, 8, 0, 0, 0));
      for (int k = 1; k <= 8; k++)
         tbl.push_back(mk(1, 0, 0, 0, 0, 0, k, 8, 8 - k, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8, 8, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(1, 1, 8'hAA, 0, 0, 0, 8, 9 + i, 1 + i, 0, 0, 0));
      for (int i = 0; i < 2; i++)
         tbl.push_back(mk(1, 1, 8'hAB, 0, 0, 0, 8, 12 + i, 4 + i, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 8, 13, 5, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8, 13, 5, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 8, 13, 5, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1, 1, 0, 8, 13, 5, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 8, 13, 5, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8, 13, 5, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8, 13, 5, 0, 0, 0));

      repeat (2) @(posedge clk);
      #1;
      chk_st("reset", 1, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      cyc(0, 0, 0, 0, 0, 0);
      chk_st("release", 1, 0, 0, 0, 0, 0, 0);

      foreach (tbl[i]) begin
         cyc(tbl[i].sel, tbl[i].tag, tbl[i].pay, tbl[i].rd, tbl[i].clr, tbl[i].tag);
         chk_st($sformatf("vec%0d", i), tbl[i].trdy, tbl[i].ri, tbl[i].wi, tbl[i].cnt,
                tbl[i].vld, tbl[i].ovf, tbl[i].udf);
      end
      chk("sb_left_tbl", 32'(exp_q.size()), 5);

      // fill to full, overflow, clear
      reset = 1'b0;
      #1;
      exp_q.delete();
      chk_st("rst2", 1, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 64; i++) cyc(1, 1, 8'(i), 0, 0, 1);
      chk_st("full", 0, 0, 0, 64, 0, 0, 0);
      cyc(1, 1, 8'hEE, 0, 0, 0);
      chk_st("ovf", 0, 0, 0, 64, 0, 1, 0);
      cyc(1, 0, 0, 0, 1, 0);
      chk_st("ovf_clr", 0, 0, 0, 64, 0, 0, 0);

      // burst from full with a push on the first pop
      cyc(1, 0, 0, 1, 0, 0);
      chk_st("rd_full", 0, 0, 0, 64, 0, 0, 0);
      cyc(1, 1, 8'h5A, 0, 0, 1);
      chk_st("pushpop", 0, 1, 1, 64, 1, 0, 0);
      repeat (7) cyc(1, 0, 0, 0, 0, 0);
      chk_st("burst2_end", 0, 8, 1, 57, 1, 0, 0);

      // abort at the 3rd word
      cyc(1, 0, 0, 1, 0, 0);
      chk_st("rd3", 0, 8, 1, 57, 0, 0, 0);
      repeat (3) cyc(1, 0, 0, 0, 0, 0);
      chk_st("word3", 0, 11, 1, 54, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk_st("abort", 1, 11, 1, 54, 0, 0, 0);

      // refill and drain across the pointer wrap
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc(1, 1, 8'(8'h80 + i), 0, 0, 1);
      chk_st("refill", 0, 11, 11, 64, 0, 0, 0);
      for (int b = 0; b < 7; b++) begin
         cyc(1, 0, 0, 1, 0, 0);
         repeat (8) cyc(1, 0, 0, 0, 0, 0);
      end
      chk_st("ri_wrap", 0, 3, 11, 8, 1, 0, 0);
      cyc(1, 0, 0, 1, 0, 0);
      repeat (8) cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk_st("drained", 0, 11, 11, 0, 0, 0, 0);
      chk("sb_left_wrap", 32'(exp_q.size()), 0);

      // asynchronous reset in the middle of a burst
      for (int i = 0; i < 8; i++) cyc(1, 1, 8'(8'hC0 + i), 0, 0, 1);
      cyc(1, 0, 0, 1, 0, 0);
      repeat (2) cyc(1, 0, 0, 0, 0, 0);
      chk_st("pre_rst", 0, 13, 19, 6, 1, 0, 0);
      #2;
      reset = 1'b0;
      exp_q.delete();
      #1;
      chk_st("mid_rst", 1, 0, 0, 0, 0, 0, 0);
      sel_bit = 1'b0;
      reset = 1'b1;
      cyc(0, 0, 0, 0, 0, 0);
      chk_st("post_rst", 1, 0, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
